// File: rtl/nibble_serial_add_ctrl.sv
// Multi-cycle W-bit adder that time-shares one external 4-bit adder slice,
// processing one nibble per cycle, least-significant nibble first.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 ovf,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_c_in,
  input  logic [3:0]           add_sum,
  input  logic                 add_c_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          c_out_reg;
  logic          ovf_reg;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        nib_a = a_reg[4*i +: 4];
        nib_b = b_reg[4*i +: 4];
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign add_a     = (state == RUN) ? nib_a : 4'd0;
  assign add_b     = (state == RUN) ? nib_b : 4'd0;
  assign add_c_in  = (state == RUN) ? carry : 1'b0;
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
  assign ovf       = ovf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            carry   <= c_in;
            idx     <= '0;
            sum_reg <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) sum_reg[4*i +: 4] <= add_sum;
          end
          carry <= add_c_out;
          if (idx == LAST) begin
            // Top nibble: its sum MSB is the result sign bit.
            state     <= DONE;
            idx       <= '0;
            c_out_reg <= add_c_out;
            ovf_reg   <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
